// File: rtl/restoring_divider_ctrl.sv
// 4-bit unsigned restoring divider that reuses an external adder_subtractor.
// Ports: clk/rst, start/dividend/divisor in; as_* adder drive and return;
// busy/done/quotient/remainder/div_by_zero results.
module restoring_divider_ctrl #(
  parameter int WIDTH = 4,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             as_select,
  output logic [WIDTH-1:0] as_a,
  output logic [WIDTH-1:0] as_b,
  input  logic [WIDTH-1:0] as_r,
  input  logic             as_cout,
  input  logic             as_ovf,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] s;

  // R stays below D (<= 7), so its top bit never feeds the shift;
  // ovf is meaningless for an unsigned divide.
  logic unused_sigs;
  assign unused_sigs = as_ovf ^ r_q[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    q_d       = q_q;
    d_d       = d_q;
    count_d   = count_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    as_select = 1'b0;
    as_a      = '0;
    as_b      = '0;
    // Shift the next dividend bit into the partial remainder.
    s         = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            q_d     = dividend;
            d_d     = divisor;
            r_d     = '0;
            count_d = CW'(ITER - 1);
            state_d = S_ITER;
          end else begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_ITER: begin
        as_select = 1'b1;
        as_a      = s;
        as_b      = d_q;
        // cout=1 means no borrow: keep the difference, quotient bit 1.
        r_d       = as_cout ? as_r : s;
        q_d       = {q_q[WIDTH-2:0], as_cout};
        count_d   = count_q - 1'b1;
        if (count_q == '0) begin
          quot_d  = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_ctrl.sv
// Scoreboard bench for restoring_divider_ctrl with a behavioural
// 4-bit adder_subtractor model closing the loop.
module tb_restoring_divider_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       as_select;
  logic [3:0] as_a;
  logic [3:0] as_b;
  logic [3:0] as_r;
  logic       as_cout;
  logic       as_ovf;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  restoring_divider_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .as_select  (as_select),
    .as_a       (as_a),
    .as_b       (as_b),
    .as_r       (as_r),
    .as_cout    (as_cout),
    .as_ovf     (as_ovf),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  logic [4:0] sum;
  logic [3:0] bx;
  always_comb begin
    bx = as_select ? ~as_b : as_b;
    sum = {1'b0, as_a} + {1'b0, bx} + {4'd0, as_select};
  end
  assign as_r    = sum[3:0];
  assign as_cout = sum[4];
  assign as_ovf  = (as_a[3] == bx[3]) && (sum[3] != as_a[3]);

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  exp_t       sbq[$];
  int         errs = 0;
  int         checks = 0;
  logic [3:0] pa[4];
  logic [3:0] pb[4];
  int         pk;
  int         ea[4] = '{1, 3, 7, 15};

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done && !rst) begin
      chk("sb_pend", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("quot", int'(quotient), int'(e.q));
        chk("rem", int'(remainder), int'(e.r));
        chk("dbz", int'(div_by_zero), int'(e.dbz));
      end
    end
  end

  task automatic run_div(input logic [3:0] dd, input logic [3:0] dv,
                         input bit hold, input bit chg);
    int   lat;
    int   sel;
    int   guard;
    exp_t e;
    lat      = 0;
    sel      = 0;
    guard    = 0;
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    e.q      = (dv == 4'd0) ? 4'hF : dd / dv;
    e.r      = (dv == 4'd0) ? dd : dd % dv;
    e.dbz    = (dv == 4'd0);
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_wait", int'(busy), 0);
    sbq.push_back(e);
    @(posedge clk);
    pk = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (chg && i == 2) begin
        dividend = 4'd1;
        divisor  = 4'd1;
      end
      if (as_select) begin
        sel++;
        if (pk < 4) begin
          pa[pk] = as_a;
          pb[pk] = as_b;
          pk++;
        end
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    chk("latency", lat, (dv == 4'd0) ? 1 : 5);
    chk("sel_cycles", sel, (dv == 4'd0) ? 0 : 4);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, int'(busy), 0);
    chk({pfx, "_done"}, int'(done), 0);
    chk({pfx, "_quot"}, int'(quotient), 0);
    chk({pfx, "_rem"}, int'(remainder), 0);
    chk({pfx, "_dbz"}, int'(div_by_zero), 0);
    chk({pfx, "_sel"}, int'(as_select), 0);
    chk({pfx, "_a"}, int'(as_a), 0);
    chk({pfx, "_b"}, int'(as_b), 0);
  endtask

  initial begin
    int dn;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;

    @(negedge clk);
    run_div(4'd7, 4'd2, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    run_div(4'd15, 4'd1, 1'b1, 1'b0);
    run_div(4'd13, 4'd7, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    run_div(4'd3, 4'd5, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_div(4'd15, 4'd15, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("probe_a%0d", i), int'(pa[i]), ea[i]);
      chk($sformatf("probe_b%0d", i), int'(pb[i]), 15);
    end

    repeat (2) @(negedge clk);
    run_div(4'd9, 4'd0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_sel", int'(as_select), 1);
    rst = 1'b1;
    #1;
    chk_zero("abort");
    dn = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_nodone", dn, 0);

    run_div(4'd14, 4'd3, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_div(4'd12, 4'd5, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("sb_left", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
